wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 103 ++++++++++
 tb/tb_wb_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back queue merging ALU and load-unit results into one register-file write port
// Optional pending-write check port enabled by macro WB_PENDING_EN.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_waddr,
    input  logic [31:0]              alu_wdata,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_waddr,
    input  logic [31:0]              mem_wdata,
    output logic                     mem_ready,
    output logic                     we,
    output logic [4:0]               waddr,
    output logic [31:0]              wdata,
`ifdef WB_PENDING_EN
    input  logic [4:0]               chk_addr,
    output logic                     chk_hit,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] count_q;
    logic [CW-1:0] free;
    logic [CW-1:0] push_cnt;
    logic          mem_push;
    logic          alu_push;
    logic          pop;

    // Readiness looks only at the registered count, so a same-cycle pop never feeds back into ready.
    assign free      = CW'(DEPTH) - count_q;
    assign mem_ready = rst && (free != '0);
    assign alu_ready = rst && ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));

    // Writes to r0 complete the handshake but are dropped here.
    assign mem_push = mem_valid && mem_ready && (mem_waddr != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_waddr != 5'd0);
    assign pop      = (count_q != '0);

    assign push_cnt = CW'(mem_push) + CW'(alu_push);
    assign alu_slot = wptr + AW'(mem_push);
    assign count    = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wptr    <= '0;
            rptr    <= '0;
            we      <= 1'b0;
            waddr   <= 5'd0;
            wdata   <= 32'd0;
        end else begin
            count_q <= count_q + push_cnt - CW'(pop);
            wptr    <= wptr + AW'(push_cnt);
            rptr    <= rptr + AW'(pop);
            we      <= pop;
            if (pop) begin
                waddr <= q_addr[rptr];
                wdata <= q_data[rptr];
            end
        end
    end

    // The load-unit entry takes the earlier slot when both sources push together.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            q_addr[wptr] <= mem_waddr;
            q_data[wptr] <= mem_wdata;
        end
        if (alu_push) begin
            q_addr[alu_slot] <= alu_waddr;
            q_data[alu_slot] <= alu_wdata;
        end
    end

`ifdef WB_PENDING_EN
    always_comb begin
        chk_hit = 1'b0;
        if (chk_addr != 5'd0) begin
            if (we && (waddr == chk_addr)) begin
                chk_hit = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (q_addr[rptr + AW'(i)] == chk_addr)) begin
                    chk_hit = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - self-checking bench for wb_queue against a queue-based reference model
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_waddr = '0;
    logic [31:0]   alu_wdata = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [4:0]    mem_waddr = '0;
    logic [31:0]   mem_wdata = '0;
    logic          mem_ready;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic [CW-1:0] count;
`ifdef WB_PENDING_EN
    logic [4:0]    chk_addr = '0;
    logic          chk_hit;
`endif

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
`ifdef WB_PENDING_EN
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [4:0]  m_addr [$];
    logic [31:0] m_data [$];
    logic        exp_we    = 1'b0;
    logic [4:0]  exp_waddr = '0;
    logic [31:0] exp_wdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a falling edge, drives inputs, checks readiness, advances the model, checks outputs.
    task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad);
        int   free;
        logic mr, ar;
        mem_valid = mv; mem_waddr = ma; mem_wdata = md;
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
`ifdef WB_PENDING_EN
        chk_addr = 5'($urandom_range(0, 7));
`endif
        #1;
        free = DEPTH - m_addr.size();
        mr   = (free >= 1);
        ar   = (free >= 2) || (free == 1 && !mv);
        check("mem_ready", 32'(mem_ready), 32'(mr));
        check("alu_ready", 32'(alu_ready), 32'(ar));
`ifdef WB_PENDING_EN
        begin
            logic hit;
            hit = exp_we && (exp_waddr == chk_addr);
            foreach (m_addr[i]) if (m_addr[i] == chk_addr) hit = 1'b1;
            if (chk_addr == 5'd0) hit = 1'b0;
            check("chk_hit", 32'(chk_hit), 32'(hit));
        end
`endif
        if (m_addr.size() > 0) begin
            exp_we    = 1'b1;
            exp_waddr = m_addr.pop_front();
            exp_wdata = m_data.pop_front();
        end else begin
            exp_we = 1'b0;
        end
        if (mv && mr && ma != 5'd0) begin m_addr.push_back(ma); m_data.push_back(md); end
        if (av && ar && aa != 5'd0) begin m_addr.push_back(aa); m_data.push_back(ad); end
        @(posedge clk);
        @(negedge clk);
        check("we",    32'(we),    32'(exp_we));
        check("waddr", 32'(waddr), 32'(exp_waddr));
        check("wdata", wdata,      exp_wdata);
        check("count", 32'(count), 32'(m_addr.size()));
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #1;
        check("rst_count",     32'(count),     32'd0);
        check("rst_we",        32'(we),        32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        check("single_cnt", 32'(count), 32'd1);
        idle();
        check("single_we",    32'(we),    32'd1);
        check("single_waddr", 32'(waddr), 32'd5);
        check("single_wdata", wdata,      32'hDEADBEEF);
        idle();
        check("single_we_off", 32'(we), 32'd0);

        // dual push: load result first
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        idle();
        check("dual_first",  32'(waddr), 32'd3);
        idle();
        check("dual_second", 32'(waddr), 32'd4);
        check("dual_data",   wdata,      32'h22);
        idle();

        // fill with both sources held valid, then drain across pointer wrap
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'($urandom_range(1, 31)), $urandom(), 1'b1, 5'($urandom_range(1, 31)), $urandom());
        repeat (5) idle();

        // zero register
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        check("zero_cnt", 32'(count), 32'd0);
        idle();
        check("zero_we", 32'(we), 32'd0);

        // reset mid-stream with entries queued
        step(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB);
        step(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
        check("pre_rst_cnt", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        mem_valid = 1'b1; alu_valid = 1'b1; mem_waddr = 5'd9; alu_waddr = 5'd8;
        #1;
        check("midrst_we",        32'(we),        32'd0);
        check("midrst_count",     32'(count),     32'd0);
        check("midrst_waddr",     32'(waddr),     32'd0);
        check("midrst_wdata",     wdata,          32'd0);
        check("midrst_mem_ready", 32'(mem_ready), 32'd0);
        check("midrst_alu_ready", 32'(alu_ready), 32'd0);
        m_addr.delete();
        m_data.delete();
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ma, aa;
            ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(1'($urandom), ma, $urandom(), 1'($urandom), aa, $urandom());
        end
        repeat (6) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
